// File: rtl/i2c_reg_slave_pkg.sv
// Shared types and constants for the I2C register-write target.
package i2c_reg_slave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEV_ADDR,
        DEV_ACK,
        BYTE_HI,
        ACK_HI,
        BYTE_LO,
        ACK_LO,
        IGNORE
    } state_t;

    // Level placed on SDA during the acknowledge clock.
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // R/W bit value of a write transfer.
    localparam logic RW_WRITE = 1'b0;

    typedef logic [8:0] reg_data_t;

endpackage

// File: rtl/i2c_bus_mon.sv
// Bus monitor: synchronises SCL/SDA into clk and flags SCL edges and START/STOP.
module i2c_bus_mon (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_q;
    logic       sda_q;
    logic       scl_s;

    // Two-flop synchronisers plus one history stage; idle bus level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_q    <= scl_sync[1];
            sda_q    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    // SDA may only change with SCL high for START/STOP, so require SCL high on both samples.
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C write-only register target: 2-byte frames {addr[6:0],d[8]}, {d[7:0]} after the device address.
module i2c_reg_slave
    import i2c_reg_slave_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h1a,
    parameter int unsigned REG_NUM    = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    input  logic [6:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       reg_wr,
    output logic [6:0] reg_wr_addr,
    output logic [8:0] reg_wr_data,
    output logic       busy
);

    state_t    state_q;
    state_t    state_d;

    logic      sda_s;
    logic      scl_rise;
    logic      scl_fall;
    logic      start_det;
    logic      stop_det;

    logic [6:0] sr;
    logic [2:0] cnt;
    logic [7:0] byte_in;
    logic       last_bit;
    logic       ack_oe;
    logic [6:0] reg_addr;
    logic       data_hi;
    logic [7:0] data_lo;
    reg_data_t  wr_word;
    logic       in_range;

    logic       ack_phase;
    logic       shift_en;
    logic       hi_load;
    logic       lo_load;
    logic       drive_set;
    logic       drive_clr;
    logic       commit;

    reg_data_t  regs [REG_NUM];

    i2c_bus_mon u_bus_mon (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda       (sda),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign byte_in  = {sr, sda_s};
    assign last_bit = (cnt == 3'd7);
    assign wr_word  = {data_hi, data_lo};
    assign in_range = (32'(reg_addr) < REG_NUM);

    // Open-drain: only ever pull low; async reset of ack_oe releases the line at once.
    assign sda = ack_oe ? ACK : 1'bz;

    assign rd_data = (32'(rd_addr) < REG_NUM) ? regs[rd_addr] : '0;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes; START/STOP override every state.
    always_comb begin
        state_d   = state_q;
        shift_en  = 1'b0;
        hi_load   = 1'b0;
        lo_load   = 1'b0;
        drive_set = 1'b0;
        drive_clr = 1'b0;
        commit    = 1'b0;
        ack_phase = (state_q == DEV_ACK) || (state_q == ACK_HI) || (state_q == ACK_LO);

        if (start_det) begin
            state_d = DEV_ADDR;
        end else if (stop_det) begin
            state_d = IDLE;
        end else begin
            // ACK clock: first SCL fall drives low, the following fall releases.
            if (ack_phase && scl_fall) begin
                drive_set = !ack_oe;
                drive_clr = ack_oe;
            end
            unique case (state_q)
                IDLE, IGNORE: begin
                end
                DEV_ADDR: begin
                    shift_en = scl_rise;
                    if (scl_rise && last_bit) begin
                        if (byte_in[7:1] == SLAVE_ADDR && byte_in[0] == RW_WRITE) begin
                            state_d = DEV_ACK;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                DEV_ACK: begin
                    if (drive_clr) state_d = BYTE_HI;
                end
                BYTE_HI: begin
                    shift_en = scl_rise;
                    if (scl_rise && last_bit) begin
                        hi_load = 1'b1;
                        state_d = ACK_HI;
                    end
                end
                ACK_HI: begin
                    if (drive_clr) state_d = BYTE_LO;
                end
                BYTE_LO: begin
                    shift_en = scl_rise;
                    if (scl_rise && last_bit) begin
                        lo_load = 1'b1;
                        state_d = ACK_LO;
                    end
                end
                ACK_LO: begin
                    commit = scl_rise && ack_oe;
                    if (drive_clr) state_d = IGNORE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Shift register, bit counter, ACK driver and frame capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            cnt      <= '0;
            ack_oe   <= 1'b0;
            reg_addr <= '0;
            data_hi  <= 1'b0;
            data_lo  <= '0;
            busy     <= 1'b0;
        end else begin
            if (start_det) begin
                busy <= 1'b1;
            end else if (stop_det) begin
                busy <= 1'b0;
            end
            if (start_det || stop_det) begin
                cnt    <= '0;
                ack_oe <= 1'b0;
            end else begin
                if (shift_en) begin
                    sr  <= byte_in[6:0];
                    cnt <= cnt + 3'd1;
                end
                if (drive_set) begin
                    ack_oe <= 1'b1;
                end else if (drive_clr) begin
                    ack_oe <= 1'b0;
                end
                if (hi_load) begin
                    reg_addr <= byte_in[7:1];
                    data_hi  <= byte_in[0];
                end
                if (lo_load) begin
                    data_lo <= byte_in;
                end
            end
        end
    end

    // Register file write port and write-report outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
            reg_wr      <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
        end else begin
            reg_wr <= 1'b0;
            if (commit && in_range) begin
                regs[reg_addr] <= wr_word;
                reg_wr         <= 1'b1;
                reg_wr_addr    <= reg_addr;
                reg_wr_data    <= wr_word;
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Self-checking bench for i2c_reg_slave: table vectors, corner sequences, random frames.
`timescale 1ns/1ps
module tb_i2c_reg_slave;

    localparam logic [6:0]  SLAVE_ADDR = 7'h1a;
    localparam int unsigned REG_NUM    = 120;
    localparam int          Q          = 60;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m_scl;
    logic       m_sda;
    logic [6:0] rd_addr;
    logic [8:0] rd_data;
    logic       reg_wr;
    logic [6:0] reg_wr_addr;
    logic [8:0] reg_wr_data;
    logic       busy;
    wire        sda;

    pullup (sda);
    assign sda = m_sda ? 1'bz : 1'b0;

    i2c_reg_slave #(
        .SLAVE_ADDR (SLAVE_ADDR),
        .REG_NUM    (REG_NUM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl         (m_scl),
        .sda         (sda),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .reg_wr      (reg_wr),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         wr_cnt = 0;
    int         drove_cnt = 0;
    logic [6:0] last_a = '0;
    logic [8:0] last_d = '0;
    logic [8:0] model_regs [128];

    // Observe write pulses and any SDA pull-low while the master has released the line.
    always @(negedge clk) begin
        if (reg_wr === 1'b1) begin
            wr_cnt = wr_cnt + 1;
            last_a = reg_wr_addr;
            last_d = reg_wr_data;
        end
        if (m_sda && sda === 1'b0) drove_cnt = drove_cnt + 1;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;
        #Q m_scl = 1'b1;
        #(2*Q) m_scl = 1'b0;
        #Q;
    endtask

    task automatic send_bits(input logic [7:0] v, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) send_bit(v[i]);
    endtask

    // Returns 1 when the target pulled SDA low during the ninth clock.
    task automatic send_byte(input logic [7:0] v, output logic acked);
        send_bits(v, 8);
        m_sda = 1'b1;
        #Q m_scl = 1'b1;
        #Q acked = (sda === 1'b0);
        #Q m_scl = 1'b0;
        #Q;
    endtask

    task automatic start_cond();
        m_sda = 1'b1;
        #Q m_scl = 1'b1;
        #Q m_sda = 1'b0;
        #Q m_scl = 1'b0;
        #Q;
    endtask

    task automatic stop_cond();
        m_sda = 1'b0;
        #Q m_scl = 1'b1;
        #Q m_sda = 1'b1;
        #Q;
    endtask

    task automatic run_frame(input logic [3:0][7:0] bs, input int n,
                             output logic [3:0] acks, output logic busy_mid);
        logic a;
        acks = '0;
        start_cond();
        busy_mid = busy;
        for (int i = 0; i < n; i++) begin
            send_byte(bs[i], a);
            acks[i] = a;
        end
        stop_cond();
        repeat (10) @(posedge clk);
    endtask

    // Spec-level frame rules: device byte must be our write address; two data bytes form
    // {addr[6:0],d[8]},{d[7:0]}; write only when addr < REG_NUM; later bytes are NACKed.
    task automatic model_frame(input logic [3:0][7:0] bs, input int n,
                               output logic [3:0] acks, output bit wr,
                               output logic [6:0] a, output logic [8:0] d);
        bit mine;
        mine = (n > 0) && (bs[0] == {SLAVE_ADDR, 1'b0});
        acks = '0;
        wr   = 1'b0;
        a    = bs[1][7:1];
        d    = {bs[1][0], bs[2]};
        if (mine) begin
            for (int i = 0; i < n && i < 3; i++) acks[i] = 1'b1;
            if (n >= 3 && int'(a) < int'(REG_NUM)) begin
                wr = 1'b1;
                model_regs[a] = d;
            end
        end
    endtask

    typedef struct {
        int               n;
        logic [3:0][7:0]  bs;
        logic [3:0]       acks;
        bit               wr;
        logic [6:0]       a;
        logic [8:0]       d;
    } vec_t;

    function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input logic [3:0] acks, input bit wr,
                                input logic [6:0] a, input logic [8:0] d);
        vec_t v;
        v.n = n;
        v.bs[0] = b0; v.bs[1] = b1; v.bs[2] = b2; v.bs[3] = b3;
        v.acks = acks; v.wr = wr; v.a = a; v.d = d;
        return v;
    endfunction

    initial begin
        vec_t       vecs [8];
        logic [3:0] acks;
        logic [3:0] exp_acks;
        logic       busy_mid;
        logic       ack1;
        bit         exp_wr;
        logic [6:0] exp_a;
        logic [8:0] exp_d;
        logic [3:0][7:0] bs;
        int         n;
        int         wr0;
        int         r;

        vecs[0] = mk(3, 8'h34, 8'h02, 8'h3F, 8'h00, 4'b0111, 1'b1, 7'h01, 9'h03F);
        vecs[1] = mk(3, 8'h34, 8'h0D, 8'hFF, 8'h00, 4'b0111, 1'b1, 7'h06, 9'h1FF);
        vecs[2] = mk(1, 8'h36, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 7'h00, 9'h000);
        vecs[3] = mk(1, 8'h35, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 7'h00, 9'h000);
        vecs[4] = mk(4, 8'h34, 8'h02, 8'h3F, 8'h55, 4'b0111, 1'b1, 7'h01, 9'h03F);
        vecs[5] = mk(3, 8'h34, 8'hF1, 8'hAA, 8'h00, 4'b0111, 1'b0, 7'h00, 9'h000);
        vecs[6] = mk(3, 8'h34, 8'hEF, 8'h5A, 8'h00, 4'b0111, 1'b1, 7'h77, 9'h15A);
        vecs[7] = mk(2, 8'h34, 8'h0D, 8'h00, 8'h00, 4'b0011, 1'b0, 7'h00, 9'h000);

        for (int i = 0; i < 128; i++) model_regs[i] = '0;

        // Reset state.
        rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1; rd_addr = 7'd5;
        #1;
        check("rst_sda", int'(sda), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_reg_wr", int'(reg_wr), 0);
        check("rst_wr_addr", int'(reg_wr_addr), 0);
        check("rst_wr_data", int'(reg_wr_data), 0);
        check("rst_rd_data", int'(rd_data), 0);
        repeat (5) @(posedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Table vectors.
        for (int v = 0; v < 8; v++) begin
            wr0 = wr_cnt;
            drove_cnt = 0;
            run_frame(vecs[v].bs, vecs[v].n, acks, busy_mid);
            check($sformatf("v%0d_acks", v), int'(acks), int'(vecs[v].acks));
            check($sformatf("v%0d_wr_count", v), wr_cnt - wr0, vecs[v].wr ? 1 : 0);
            check($sformatf("v%0d_sda_driven", v), int'(drove_cnt != 0), int'(vecs[v].acks != 0));
            check($sformatf("v%0d_busy_after", v), int'(busy), 0);
            if (vecs[v].acks[0]) check($sformatf("v%0d_busy_mid", v), int'(busy_mid), 1);
            if (vecs[v].wr) begin
                model_regs[vecs[v].a] = vecs[v].d;
                check($sformatf("v%0d_wr_addr", v), int'(last_a), int'(vecs[v].a));
                check($sformatf("v%0d_wr_data", v), int'(last_d), int'(vecs[v].d));
                rd_addr = vecs[v].a;
                #1 check($sformatf("v%0d_rd_data", v), int'(rd_data), int'(vecs[v].d));
            end
        end

        // Repeated START after 4 bits of the register-address byte.
        wr0 = wr_cnt;
        start_cond();
        send_byte(8'h34, ack1);
        check("rs_dev_ack", int'(ack1), 1);
        send_bits(8'hA5, 4);
        bs[0] = 8'h34; bs[1] = 8'h04; bs[2] = 8'h01; bs[3] = 8'h00;
        run_frame(bs, 3, acks, busy_mid);
        check("rs_acks", int'(acks), 4'b0111);
        check("rs_wr_count", wr_cnt - wr0, 1);
        check("rs_wr_addr", int'(last_a), 2);
        check("rs_wr_data", int'(last_d), 9'h001);
        model_regs[2] = 9'h001;
        rd_addr = 7'd2;
        #1 check("rs_rd_data", int'(rd_data), 9'h001);

        // STOP in the middle of the data byte aborts the frame.
        wr0 = wr_cnt;
        start_cond();
        send_byte(8'h34, ack1);
        send_byte(8'h06, ack1);
        send_bits(8'hFF, 4);
        stop_cond();
        repeat (10) @(posedge clk);
        check("abort_wr_count", wr_cnt - wr0, 0);
        check("abort_busy", int'(busy), 0);
        check("abort_sda", int'(sda), 1);
        rd_addr = 7'd3;
        #1 check("abort_rd_data", int'(rd_data), int'(model_regs[3]));

        // Random frames against the reference model.
        for (int t = 0; t < 20; t++) begin
            r = int'($urandom_range(0, 7));
            bs[0] = (r < 5) ? 8'h34 : (r == 5) ? 8'h35 : (r == 6) ? 8'h36 : 8'($urandom);
            bs[1] = 8'($urandom);
            bs[2] = 8'($urandom);
            bs[3] = 8'($urandom);
            n = int'($urandom_range(1, 4));
            model_frame(bs, n, exp_acks, exp_wr, exp_a, exp_d);
            wr0 = wr_cnt;
            run_frame(bs, n, acks, busy_mid);
            check($sformatf("rnd%0d_acks", t), int'(acks), int'(exp_acks));
            check($sformatf("rnd%0d_wr_count", t), wr_cnt - wr0, exp_wr ? 1 : 0);
            if (exp_wr) begin
                check($sformatf("rnd%0d_wr_addr", t), int'(last_a), int'(exp_a));
                check($sformatf("rnd%0d_wr_data", t), int'(last_d), int'(exp_d));
            end
        end

        // Full readback including the out-of-range window.
        for (int a = 0; a < 128; a++) begin
            rd_addr = 7'(a);
            #1 check($sformatf("readback_%0d", a), int'(rd_data),
                     (a < int'(REG_NUM)) ? int'(model_regs[a]) : 0);
        end

        // Reset asserted while the target is driving an ACK.
        start_cond();
        send_bits(8'h34, 8);
        m_sda = 1'b1;
        #Q;
        check("ack_driven", int'(sda), 0);
        rst_n = 1'b0;
        #1 check("rst_mid_ack_sda", int'(sda), 1);
        for (int i = 0; i < 128; i++) model_regs[i] = '0;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        #Q m_scl = 1'b1;
        #(2*Q) m_scl = 1'b0;
        #Q;
        // Without a fresh START the block must stay silent.
        send_byte(8'h34, ack1);
        check("post_rst_no_ack", int'(ack1), 0);
        check("post_rst_busy", int'(busy), 0);
        stop_cond();
        repeat (10) @(posedge clk);
        rd_addr = 7'd1;
        #1 check("post_rst_reg1", int'(rd_data), int'(model_regs[1]));
        rd_addr = 7'd2;
        #1 check("post_rst_reg2", int'(rd_data), int'(model_regs[2]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
